instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Producer side of the instruction path. Holds the fetch PC and issues word reads to instruction memory.
//  Buffers returned words in a small in-order queue and presents them, with their PC, to the control/decode stage.
//  Flushes and re-steers on branch/jump redirects from execute.
//  Halts permanently (until reset) when decode flags an undefined instruction.
// PARAMETERS
//  XLEN          32            address / PC width
//  RESET_VECTOR  32'h0000_0000 first fetch address after reset
//  FIFO_DEPTH    2             instruction buffer entries; also the max in-flight + buffered request count
// PORTS
//  CLK            in   1     single clock, rising edge
//  rst_n          in   1     synchronous, active-low reset
//  IMEM_Req       out  1     read request valid
//  IMEM_Addr      out  XLEN  word-aligned read address (bits[1:0]=0)
//  IMEM_Gnt       in   1     request accepted this cycle when IMEM_Req=1
//  IMEM_Rvalid    in   1     read data valid; in order, >=1 cycle after grant, max one per cycle
//  IMEM_Rdata     in   32    instruction word
//  Instr_Valid    out  1     Instr/Instr_PC valid toward decode
//  Instr_Ready    in   1     decode consumes the instruction this cycle
//  Instr          out  32    instruction word; decode slices Opcode/Funct3/Funct7 from it
//  Instr_PC       out  XLEN  PC of Instr
//  undef_instr    in   1     decode verdict on the currently presented Instr
//  Redirect       in   1     taken branch or jump
//  Redirect_Addr  in   XLEN  new fetch target; bits[1:0] ignored and forced to 0
//  Halted         out  1     fetch stopped on an undefined instruction
//  Trap_PC        out  XLEN  PC of the offending instruction
// BEHAVIOUR
//  Reset (rst_n=0 at a CLK edge):
//   - IMEM_Req=0, IMEM_Addr=RESET_VECTOR, Instr_Valid=0, Instr=0, Instr_PC=0, Halted=0, Trap_PC=0.
//   - FIFO empty, all counters 0, state=RUN. Reset mid-operation discards all in-flight data; the memory shares the reset.
//  Requests:
//   - IMEM_Req=1 in RUN when (outstanding + buffered) < FIFO_DEPTH and no redirect this cycle.
//   - First request is in the first cycle after rst_n rises.
//   - Handshake: on IMEM_Req & IMEM_Gnt, the address is accepted and fetch PC += 4 (mod 2^XLEN, wraps).
//   - IMEM_Addr holds stable while IMEM_Req=1 and IMEM_Gnt=0.
//  Responses: IMEM_Rvalid pushes {Rdata, PC} into the FIFO; the outstanding count decrements.
//   - The FIFO can never overflow, by the credit rule above.
//  Decode side:
//   - Instr_Valid = FIFO not empty; Instr/Instr_PC = head entry.
//   - Instr_Valid & Instr_Ready pops the head.
//   - Latency: Rvalid at cycle N gives Instr_Valid at N+1 at the earliest.
//   - A push and a pop in the same cycle are both legal; they are also legal when the FIFO is full.
//  Redirect, effective when Redirect=1 in RUN:
//   - FIFO flushed; Instr_Valid=0 next cycle.
//   - Fetch PC <= {Redirect_Addr[XLEN-1:2], 2'b00}.
//   - drop_cnt <= outstanding, counted after this cycle's Rvalid/grant. Later Rvalids decrement drop_cnt and are discarded.
//   - Requests resume the next cycle. A response in the redirect cycle itself is discarded.
//   - A grant in the redirect cycle is illegal, since Req=0 in that cycle.
//  Halt (state RUN->HALT): on Instr_Valid & Instr_Ready & undef_instr.
//   - Instr is not popped. Trap_PC <= Instr_PC, and Halted=1 from the next cycle.
//   - In HALT: IMEM_Req=0 and Instr_Valid=0. Late Rvalids are absorbed and ignored.
//   - Redirect is ignored. Only reset leaves HALT.
//  Priority in the same cycle: halt > redirect > normal push/pop.
//  FSM: RUN, HALT. No other states.
//   - Outstanding counter width is clog2(FIFO_DEPTH+1), and it saturates in neither direction.
// STRUCTURE
//  fetch_pkg: RESET_VECTOR default, state encoding (RUN/HALT), PC increment constant 4.
//  Sub-module fetch_fifo: synchronous FIFO of {32-bit instr, XLEN PC}, depth FIFO_DEPTH.
//   - Ports: push, pop, flush, full, empty, count. Flush has priority over push.
//  Top level: PC register, credit/outstanding counter, drop counter, FSM, output muxing.
// TESTING
//  1 Reset then zero-wait memory (Gnt=1, Rvalid next cycle), Ready=1 -> Instr_PC sequence 0x0,0x4,0x8,...
//    One instr/cycle sustained after a 2-cycle start; IMEM_Addr=0x0 in the first cycle after reset.
//  2 Ready=0 for 5 cycles -> exactly 2 requests issued, Req=0 after that, FIFO holds PC 0x0/0x4.
//    Ready=1 -> both pop in order, then fetch resumes at 0x8.
//  3 Redirect to 0x0000_0103 with 2 requests in flight -> the next IMEM_Addr is 0x100.
//    The 2 late Rvalids are dropped; first Instr_PC after the redirect is 0x100.
//  4 Gnt held 0 for 3 cycles -> IMEM_Req and IMEM_Addr stay stable.
//    No PC advance until the grant; then PC+4.
//  5 undef_instr on the instr at PC 0x8, with Redirect asserted in the same cycle -> Halted=1, Trap_PC=0x8.
//    IMEM_Req stays 0 and Instr_Valid stays 0 for 20 cycles; the redirect is ignored.
//  6 rst_n=0 for one cycle mid-stream, with data in flight -> all outputs return to reset values.
//    Fetch restarts at RESET_VECTOR; a PC wrap from 0xFFFF_FFFC to 0x0 is also checked.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer; each entry holds {instruction word, PC}.
// Flush wins over push; a push while full is accepted only alongside a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Next pointers, occupancy and storage contents.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, request credit, in-order buffer toward decode,
// redirect flush with late-response dropping, and a sticky halt on undefined instructions.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_RUN  | fetching and presenting instructions
//   ST_HALT | stopped on an undefined instruction; only reset leaves it
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int unsigned      FIFO_DEPTH   = 2
) (
  input  logic            CLK,
  input  logic            rst_n,
  output logic            IMEM_Req,
  output logic [XLEN-1:0] IMEM_Addr,
  input  logic            IMEM_Gnt,
  input  logic            IMEM_Rvalid,
  input  logic [31:0]     IMEM_Rdata,
  output logic            Instr_Valid,
  input  logic            Instr_Ready,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] Instr_PC,
  input  logic            undef_instr,
  input  logic            Redirect,
  input  logic [XLEN-1:0] Redirect_Addr,
  output logic            Halted,
  output logic [XLEN-1:0] Trap_PC
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = 32 + XLEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   fifo_rdata;

  logic            running, head_valid, halt_evt, redirect_evt;
  logic            pop, push, grant, rsp_drop;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_pc;

  // rsp_pc tracks the address of the oldest response that will be kept,
  // which works because requests are sequential between redirects.
  always_comb begin
    running      = rst_n && (state_q == ST_RUN);
    head_valid   = running && !fifo_empty;
    halt_evt     = head_valid && Instr_Ready && undef_instr;
    redirect_evt = running && Redirect && !halt_evt;
    pop          = head_valid && Instr_Ready && !undef_instr;
    credit_used  = {1'b0, out_cnt_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
    IMEM_Req     = running && !Redirect && !(fifo_full && !pop) &&
                   (credit_used < (CW+1)'(FIFO_DEPTH));
    grant        = IMEM_Req && IMEM_Gnt;
    rsp_drop     = IMEM_Rvalid && (drop_cnt_q != '0);
    push         = IMEM_Rvalid && !rsp_drop && running && !redirect_evt && !halt_evt;
    redirect_pc  = Redirect_Addr & ~XLEN'(3);

    state_d    = halt_evt ? ST_HALT : state_q;
    out_cnt_d  = out_cnt_q + CW'(grant) - CW'(IMEM_Rvalid);
    drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    trap_pc_d  = trap_pc_q;

    if (grant) pc_d = pc_q + XLEN'(PC_INC);
    if (push)  rsp_pc_d = rsp_pc_q + XLEN'(PC_INC);
    if (redirect_evt) begin
      pc_d       = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_cnt_d = out_cnt_d;
    end
    if (halt_evt) trap_pc_d = Instr_PC;
  end

  // State, PC and counter registers.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      trap_pc_q  <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      trap_pc_q  <= trap_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_evt),
    .wdata ({IMEM_Rdata, rsp_pc_q}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign IMEM_Addr   = pc_q;
  assign Instr_Valid = head_valid;
  assign Instr       = head_valid ? fifo_rdata[EW-1:XLEN] : 32'h0;
  assign Instr_PC    = head_valid ? fifo_rdata[XLEN-1:0] : '0;
  assign Halted      = (state_q == ST_HALT);
  assign Trap_PC     = trap_pc_q;

endmodule
